// File: rtl/maple_rx_pkg.sv
// maple_rx_pkg: shared state encoding, TUSER layout and helpers for the Maple Bus receive framer
package maple_rx_pkg;
   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      RECV  = 4'b0010,
      SKIP  = 4'b0100,
      FLUSH = 4'b1000
   } state_t;
   localparam int USER_W  = 5;
   localparam int U_CRC   = 0;
   localparam int U_LEN   = 1;
   localparam int U_TMO   = 2;
   localparam int U_END   = 3;
   localparam int U_ABORT = 4;
   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction
endpackage

// File: rtl/maple_rx_fifo.sv
// maple_rx_fifo: sync FIFO with a registered output stage and an occupancy count
module maple_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop_ready,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_data,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] mem_cnt;
   logic load, from_mem, bypass, to_mem;
   // an empty store lets a push go straight to the output register
   always_comb begin
      load     = !out_valid || pop_ready;
      from_mem = load && mem_cnt != '0;
      bypass   = load && mem_cnt == '0 && push;
      to_mem   = push && !bypass;
   end
   assign level = mem_cnt + {{AW{1'b0}}, out_valid};
   always_ff @(posedge aclk) if (to_mem) mem[wr_ptr] <= wdata;
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_cnt   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (to_mem) wr_ptr <= wr_ptr + 1'b1;
         if (from_mem) rd_ptr <= rd_ptr + 1'b1;
         if (from_mem) out_data <= mem[rd_ptr];
         else if (bypass) out_data <= wdata;
         if (load) out_valid <= from_mem || bypass;
         mem_cnt <= mem_cnt + {{AW{1'b0}}, to_mem} - {{AW{1'b0}}, from_mem};
      end
   end
endmodule

// File: rtl/maple_rx_framer.sv
// maple_rx_framer: packs decoded Maple Bus bytes into AXI-Stream frames with per-frame status on TUSER
module maple_rx_framer
   import maple_rx_pkg::*;
#(
   parameter int TDATA_WIDTH    = 32,
   parameter int FIFO_DEPTH     = 64,
   parameter int MAX_BYTES      = 1028,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [7:0]                    s_byte,
   input  logic                          s_byte_valid,
   input  logic                          start_frame,
   input  logic                          start_with_crc,
   input  logic                          start_reset,
   input  logic                          end_frame,
   input  logic                          end_frame_error,
   input  logic                          enable,
   output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
   output logic [TDATA_WIDTH/8-1:0]      m_axis_tkeep,
   output logic [TDATA_WIDTH/8-1:0]      m_axis_tstrb,
   output logic                          m_axis_tlast,
   output logic [4:0]                    m_axis_tuser,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          receiving,
   output logic                          frame_dropped,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int BYTES     = TDATA_WIDTH / 8;
   localparam int MAX_BEATS = ceil_div(MAX_BYTES, BYTES);
   localparam int LW        = BYTES > 1 ? $clog2(BYTES) : 1;
   localparam int CW        = $clog2(MAX_BYTES + 1);
   localparam int TW        = $clog2(TIMEOUT_CYCLES);
   localparam int FW        = TDATA_WIDTH + BYTES + 1 + USER_W;

   if (FIFO_DEPTH < MAX_BEATS) begin : g_depth_check
      $error("FIFO_DEPTH must hold at least one maximum-length frame");
   end

   state_t state, state_n;
   logic [CW-1:0] byte_cnt;
   logic [LW-1:0] lane_idx;
   logic [TDATA_WIDTH-1:0] pack, beat_data;
   logic [BYTES-1:0] beat_keep;
   logic [USER_W-1:0] beat_user;
   logic [USER_W-1:1] flags;
   logic [7:0] hold_byte, crc_acc;
   logic [TW-1:0] tmo_cnt;
   logic hold_valid, crc_mode, restart_pending, restart_crc;
   logic start, end_any, tmo_hit, rx_tmo, byte_ok, len_over;
   logic push_full, push_last, push, admit, launch, launch_crc;
   logic [FW-1:0] fifo_out;

   // space for a maximum frame is reserved up front, counting a push landing this cycle
   always_comb begin
      start      = start_frame || start_with_crc || start_reset;
      end_any    = end_frame || end_frame_error;
      tmo_hit    = tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
      rx_tmo     = tmo_hit && !s_byte_valid;
      byte_ok    = state == RECV && s_byte_valid;
      len_over   = byte_cnt == CW'(MAX_BYTES);
      push_full  = byte_ok && !len_over && hold_valid && lane_idx == LW'(BYTES - 1);
      push_last  = state == FLUSH && hold_valid;
      push       = push_full || push_last;
      admit      = enable && int'(fifo_level) + int'(push) + MAX_BEATS <= FIFO_DEPTH;
      launch     = 1'b0;
      launch_crc = start_with_crc;
      state_n    = state;
      case (state)
         IDLE:  launch = start;
         RECV:  if (end_any || rx_tmo || start) state_n = FLUSH;
         SKIP:  if (end_any || tmo_hit) state_n = IDLE; else launch = start;
         FLUSH: begin
            state_n    = IDLE;
            launch     = restart_pending || start;
            launch_crc = restart_pending ? restart_crc : start_with_crc;
         end
         default: state_n = IDLE;
      endcase
      if (launch) state_n = admit ? RECV : SKIP;
   end

   always_comb begin
      beat_data = '0;
      beat_keep = '0;
      for (int i = 0; i < BYTES; i++) begin
         beat_data[8*i +: 8] = LW'(i) == lane_idx ? hold_byte : LW'(i) < lane_idx ? pack[8*i +: 8] : 8'h00;
         beat_keep[i]        = LW'(i) <= lane_idx;
      end
      beat_user = push_last ? {flags, crc_mode && crc_acc != 8'h00} : '0;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state           <= IDLE;
         frame_dropped   <= 1'b0;
         tmo_cnt         <= '0;
         byte_cnt        <= '0;
         lane_idx        <= '0;
         pack            <= '0;
         hold_byte       <= '0;
         hold_valid      <= 1'b0;
         crc_acc         <= '0;
         crc_mode        <= 1'b0;
         flags           <= '0;
         restart_pending <= 1'b0;
         restart_crc     <= 1'b0;
      end else begin
         state         <= state_n;
         frame_dropped <= launch && !admit;
         tmo_cnt       <= (launch || byte_ok || !(state_n inside {RECV, SKIP})) ? '0 : tmo_cnt + 1'b1;
         if (launch) begin
            byte_cnt   <= '0;
            lane_idx   <= '0;
            pack       <= '0;
            hold_byte  <= '0;
            hold_valid <= 1'b0;
            crc_acc    <= '0;
            flags      <= '0;
            crc_mode   <= launch_crc;
         end else if (byte_ok && len_over) flags[U_LEN] <= 1'b1;
         else if (byte_ok) begin
            byte_cnt   <= byte_cnt + 1'b1;
            crc_acc    <= crc_acc ^ s_byte;
            hold_byte  <= s_byte;
            hold_valid <= 1'b1;
            if (hold_valid) begin
               pack[8*lane_idx +: 8] <= hold_byte;
               lane_idx              <= push_full ? '0 : lane_idx + 1'b1;
            end
         end
         // end beats timeout, timeout beats a new start
         if (state == RECV) begin
            if (end_frame_error) flags[U_END] <= 1'b1;
            if (!end_any && rx_tmo) flags[U_TMO] <= 1'b1;
            if (!end_any && !rx_tmo && start) begin
               flags[U_ABORT]  <= 1'b1;
               restart_pending <= 1'b1;
               restart_crc     <= start_with_crc;
            end
         end
         if (state == FLUSH) restart_pending <= 1'b0;
      end
   end

   maple_rx_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .push      (push),
      .wdata     ({beat_user, push_last, beat_keep, beat_data}),
      .pop_ready (m_axis_tready),
      .out_valid (m_axis_tvalid),
      .out_data  (fifo_out),
      .level     (fifo_level)
   );

   assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = fifo_out;
   assign m_axis_tstrb = m_axis_tkeep;
   assign receiving    = state != IDLE;
endmodule

// File: tb/tb_maple_rx_framer.sv
// tb_maple_rx_framer: scoreboard bench for maple_rx_framer (32-bit lanes, small FIFO, short limits)
module tb_maple_rx_framer;
   localparam int W = 32, NB = 4, DEPTH = 4, MAXB = 8, TMO = 50;
   typedef struct {
      logic [W-1:0]  d;
      logic [NB-1:0] k;
      logic          l;
      logic [4:0]    u;
   } beat_t;

   logic aclk = 1'b0, aresetn = 1'b0;
   logic [7:0] s_byte = '0;
   logic s_byte_valid = 0, start_frame = 0, start_with_crc = 0, start_reset = 0;
   logic end_frame = 0, end_frame_error = 0, enable = 1, m_axis_tready = 1;
   logic [W-1:0] m_axis_tdata;
   logic [NB-1:0] m_axis_tkeep, m_axis_tstrb;
   logic m_axis_tlast, m_axis_tvalid, receiving, frame_dropped;
   logic [4:0] m_axis_tuser;
   logic [$clog2(DEPTH):0] fifo_level;

   beat_t exp_q[$];
   beat_t mt;
   logic [W-1:0] mk;
   logic [7:0] fb [16];
   int n_chk = 0, n_err = 0;
   bit rand_bp = 0;

   always #5 aclk = ~aclk;

   maple_rx_framer #(.TDATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .MAX_BYTES(MAXB), .TIMEOUT_CYCLES(TMO)) dut (
      .aclk(aclk), .aresetn(aresetn), .s_byte(s_byte), .s_byte_valid(s_byte_valid),
      .start_frame(start_frame), .start_with_crc(start_with_crc), .start_reset(start_reset),
      .end_frame(end_frame), .end_frame_error(end_frame_error), .enable(enable),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tstrb(m_axis_tstrb),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .receiving(receiving), .frame_dropped(frame_dropped),
      .fifo_level(fifo_level)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge aclk);
      #1;
      if (rand_bp) m_axis_tready = 1'($urandom_range(0, 1));
   endtask

   task automatic fill(input logic [7:0] base);
      for (int i = 0; i < 16; i++) fb[i] = base + 8'(i);
   endtask

   // reference packing: first MAX bytes, lane 0 first, status only on the last beat
   task automatic exp_frame(input int n, input logic crc, input logic [4:0] fl);
      int m;
      logic [7:0] x;
      logic [4:0] u;
      beat_t t;
      m = n > MAXB ? MAXB : n;
      x = 8'h00;
      for (int i = 0; i < m; i++) x ^= fb[i];
      u = fl | {3'b000, n > MAXB, crc && x != 8'h00};
      for (int i = 0; i < m; i += NB) begin
         t.d = '0;
         t.k = '0;
         for (int j = 0; j < NB && i + j < m; j++) begin
            t.d[8*j +: 8] = fb[i+j];
            t.k[j] = 1'b1;
         end
         t.l = i + NB >= m;
         t.u = t.l ? u : 5'b0;
         exp_q.push_back(t);
      end
   endtask

   // endk: 0 end_frame, 1 end_frame_error, 2 end+start together, 3 silence, 4 end with last byte
   task automatic run_frame(input int n, input logic crc, input int endk, input bit drop);
      if (!drop) exp_frame(n, crc, {1'b0, endk == 1, endk == 3, 2'b00});
      start_with_crc = crc;
      start_frame = !crc;
      cyc();
      start_with_crc = 0;
      start_frame = 0;
      check("receiving_rise", receiving, 1);
      check("frame_dropped", frame_dropped, drop);
      cyc();
      check("drop_pulse_len", frame_dropped, 0);
      for (int i = 0; i < n; i++) begin
         s_byte = fb[i];
         s_byte_valid = 1;
         end_frame = endk == 4 && i == n - 1;
         cyc();
      end
      s_byte_valid = 0;
      end_frame = 0;
      if (endk == 3) begin
         int w = 0;
         while (receiving && w < 200) begin
            cyc();
            w++;
         end
         check("timeout_cycles", w, TMO + 1);
         check("timeout_idle", receiving, 0);
      end else begin
         if (endk != 4) begin
            end_frame = endk != 1;
            end_frame_error = endk == 1;
            start_frame = endk == 2;
            cyc();
         end
         end_frame = 0;
         end_frame_error = 0;
         start_frame = 0;
         cyc();
         cyc();
         check("idle_after_end", receiving, 0);
      end
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 300 && (exp_q.size() != 0 || fifo_level != 0); c++) cyc();
      check("drain", exp_q.size(), 0);
   endtask

   always @(negedge aclk) begin
      if (m_axis_tvalid && m_axis_tready) begin
         if (exp_q.size() == 0) check("spurious_beat", m_axis_tvalid, 0);
         else begin
            mt = exp_q.pop_front();
            for (int j = 0; j < NB; j++) mk[8*j +: 8] = {8{mt.k[j]}};
            check("tdata", m_axis_tdata & mk, mt.d);
            check("tkeep", m_axis_tkeep, mt.k);
            check("tstrb", m_axis_tstrb, mt.k);
            check("tlast", m_axis_tlast, mt.l);
            check("tuser", m_axis_tuser, mt.u);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e;
      repeat (3) cyc();
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_tuser", m_axis_tuser, 0);
      check("rst_tkeep", m_axis_tkeep, 0);
      check("rst_tdata", m_axis_tdata, 0);
      check("rst_receiving", receiving, 0);
      check("rst_dropped", frame_dropped, 0);
      check("rst_level", fifo_level, 0);
      aresetn = 1;
      cyc();
      fill(8'h01); fb[5] = 8'h01; run_frame(6, 1, 0, 0);
      fb[5] = 8'h00; run_frame(6, 1, 0, 0);
      fill(8'h10); run_frame(10, 0, 0, 0);
      fill(8'h61); run_frame(3, 0, 1, 0);
      fill(8'h71); run_frame(5, 1, 4, 0);
      fill(8'h81); run_frame(4, 0, 2, 0);
      fill(8'h91); run_frame(3, 0, 3, 0);
      // start mid-frame aborts the first frame and opens the second
      fill(8'h21);
      exp_frame(2, 0, 5'b10000);
      start_frame = 1; cyc(); start_frame = 0;
      for (int i = 0; i < 2; i++) begin
         s_byte = fb[i]; s_byte_valid = 1; cyc();
      end
      s_byte_valid = 0;
      fill(8'h31); run_frame(4, 0, 0, 0);
      wait_drain();
      enable = 0;
      fill(8'hA1); run_frame(3, 0, 0, 1);
      check("level_enable_drop", fifo_level, 0);
      enable = 1;
      m_axis_tready = 0;
      fill(8'h01); fb[5] = 8'h01; run_frame(6, 1, 0, 0);
      fill(8'h51); run_frame(3, 0, 0, 0);
      check("level_full", fifo_level, 3);
      fill(8'hB1); run_frame(5, 0, 0, 1);
      check("level_hold", fifo_level, 3);
      m_axis_tready = 1;
      wait_drain();
      // reset with buffered beats and a partial frame discards everything
      m_axis_tready = 0;
      fill(8'h41); run_frame(6, 1, 0, 0);
      start_frame = 1; cyc(); start_frame = 0;
      s_byte = 8'hEE; s_byte_valid = 1; cyc(); cyc(); s_byte_valid = 0;
      aresetn = 0; cyc(); cyc(); aresetn = 1;
      exp_q.delete();
      check("rst_mid_level", fifo_level, 0);
      check("rst_mid_tvalid", m_axis_tvalid, 0);
      check("rst_mid_receiving", receiving, 0);
      m_axis_tready = 1;
      cyc();
      rand_bp = 1;
      for (int f = 0; f < 6; f++) begin
         for (int c = 0; c < 100 && fifo_level > 2; c++) cyc();
         for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
         e = $urandom_range(0, 2);
         run_frame($urandom_range(1, 10), 1'($urandom_range(0, 1)), e == 2 ? 4 : e, 0);
      end
      rand_bp = 0;
      m_axis_tready = 1;
      wait_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/maple_rx_framer.md
# maple_rx_framer

Parametrised Maple Bus receive framer: consumes decoded bytes and start/end pulses from the existing synchronizer/decoder chain. It packs bytes into a configurable-width AXI-Stream. It checks CRC and frame length, applies an idle timeout, and buffers whole frames in an internal FIFO with per-frame status on TUSER. It supersedes the fixed 8-bit receiver top-level state machine and single-byte buffer.

## Interface
- TDATA_WIDTH, 32, output width in bits; 8/16/32/64; BYTES = TDATA_WIDTH/8
- FIFO_DEPTH, 64, beats; power of 2; must be ≥ MAX_BEATS = ceil(MAX_BYTES/BYTES), elaboration error otherwise
- MAX_BYTES, 1028, max stored bytes per frame
- TIMEOUT_CYCLES, 100000, aclk cycles without a byte before a frame is aborted; ≥ 2
- aclk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low; clock aclk
- s_byte  in  8  decoded byte
- s_byte_valid  in  1  one-cycle strobe for s_byte
- start_frame, start_with_crc, start_reset  in  1 each  one-cycle start pulses; start_with_crc arms the CRC check
- end_frame, end_frame_error  in  1 each  one-cycle end pulses
- enable  in  1  store frames when 1
- m_axis_tdata  out  TDATA_WIDTH  packed bytes; byte 0 in lane 0
- m_axis_tkeep, m_axis_tstrb  out  BYTES  contiguous low lanes; tstrb = tkeep
- m_axis_tlast  out  1  last beat of frame
- m_axis_tuser  out  5  [0] crc_err, [1] len_err, [2] timeout, [3] end_err, [4] aborted; nonzero only on the tlast beat
- m_axis_tvalid  out  1 / m_axis_tready  in  1
- receiving  out  1  state ≠ IDLE
- frame_dropped  out  1  one-cycle pulse when a start is skipped
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied beats

## Operation
- start = start_frame | start_with_crc | start_reset.
- States:
  - IDLE: on start, go to RECV if enable && free ≥ MAX_BEATS. Otherwise go to SKIP and pulse frame_dropped.
  - RECV: on end_*, go to FLUSH. On timeout, go to FLUSH with timeout=1. On start, go to FLUSH with aborted=1 and restart_pending=1, latching the crc mode of the new start.
  - SKIP: ignore bytes. On end_* or timeout, go to IDLE. On start, re-evaluate as from IDLE.
  - FLUSH: one cycle. Leaves to IDLE, or re-evaluates the pending start.
- On entering RECV, clear byte count, lane index, hold register, crc accumulator, and status flags.
- One-byte hold register, so the final byte is always known:
  - A new byte moves the held byte into packer lane lane_idx.
  - If lane_idx = BYTES−1, push the full beat with tlast=0, and lane_idx wraps to 0.
  - The new byte becomes the held byte.
- Bytes beyond MAX_BYTES are discarded and set len_err.
- FLUSH with a valid hold: push packer lanes plus the held byte as one beat, with tkeep = (1<<(lane_idx+1))−1, tlast=1, and tuser = flags.
- FLUSH with an empty hold (zero-byte frame): push nothing.
- CRC: accumulator = XOR of all accepted bytes, including the trailing CRC byte. crc_err = crc_mode && acc ≠ 0. The CRC byte is forwarded.
- end_frame_error sets end_err.
- Timeout counter clears on each accepted byte and on RECV entry.
- Push never overflows, because space is reserved at frame start. The FIFO is a standard sync FIFO; frames are never reordered.

## Timing
- Reset values: m_axis_tvalid=0, tlast=0, tuser=0, tkeep=0, tdata=0, receiving=0, frame_dropped=0, fifo_level=0. FSM resets to IDLE and the FIFO is emptied.
- Reset mid-frame discards all partial and buffered data.
- A start pulse changes state on the next edge; receiving rises 1 cycle after start.
- Push to m_axis_tvalid latency: 1 cycle. A beat is transferred when tvalid && tready; outputs are held stable while tready=0.
- A byte and end_* in the same cycle: the byte is accepted, then FLUSH follows.
- A byte during FLUSH is dropped.
- Start and end in the same cycle: end wins, and start is ignored.
- A simultaneous push and pop on a full FIFO is legal; level stays unchanged.
- Timeout fires when the counter reaches TIMEOUT_CYCLES−1.

## Structure
- Package maple_rx_pkg holds:
  - state one-hot encoding (IDLE, RECV, SKIP, FLUSH)
  - TUSER bit index constants and width (5)
  - function ceil_div
- Sub-module maple_rx_fifo (sync FIFO, width TDATA_WIDTH+BYTES+1+5, depth FIFO_DEPTH, registered output, level output).
- Framer FSM and packer live in maple_rx_framer.

## Test plan
- W=32, start_with_crc, bytes 01 02 03 04 05 then CRC 01, end_frame -> beats {04030201, keep F, last 0} and {0105, keep 3, last 1, tuser 0}.
- Same frame with CRC byte 00 -> identical data, tuser = 00001 (crc_err).
- MAX_BYTES=8, 10 bytes -> exactly 8 bytes emitted over 2 beats; last beat keep F, tuser = 00010.
- TIMEOUT_CYCLES=50, 3 bytes then silence -> after 50 idle cycles one beat, keep 7, tuser = 00100, receiving drops.
- start_frame mid-frame after 2 bytes, then 4 bytes, end -> frame 1: keep 3, tuser 10000; frame 2: keep F, tuser 0.
- enable=0 at start, or tready held 0 until free < MAX_BEATS -> frame_dropped pulses once, no beats for that frame; fifo_level is unchanged.
